// File: rtl/fifo_sync_gen2.sv
// fifo_sync_gen2: synchronous FIFO, DEPTH = 2**ADDR_WIDTH entries, all usable.
// Occupancy level, programmable almost-full/almost-empty flags, sync flush,
// registered error pulses for push-on-full / pop-on-empty.
// Optional macro FIFO_FWFT_EN selects first-word fall-through read path;
// undefined gives a registered read with one cycle of latency.
module fifo_sync_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  push_err_on_full,
  output logic                  pop_err_on_empty
);

  localparam int              DEPTH = 2**ADDR_WIDTH;
  localparam int              PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   AF_L  = PW'(AF_LEVEL);
  localparam logic [PW-1:0]   AE_L  = PW'(AE_LEVEL);

  // Handshake: push acts as valid from the producer with ~full as its ready;
  // pop acts as ready from the consumer with ~empty as its valid. A transfer
  // happens only on an edge where both sides agree; a request that is not
  // matched leaves state untouched and raises the matching error pulse.

  logic [PW-1:0]         w_ptr_q, w_ptr_d;
  logic [PW-1:0]         r_ptr_q, r_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_err_q, pop_err_q;
  logic                  push_acc, pop_acc;

  // Status flags derived combinationally from the registered pointers.
  always_comb begin
    empty        = (w_ptr_q == r_ptr_q);
    full         = (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]) &&
                   (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]);
    level        = w_ptr_q - r_ptr_q;
    almost_full  = (level >= AF_L);
    almost_empty = (level <= AE_L);
    push_acc     = push & ~full;
    pop_acc      = pop & ~empty;
  end

  // Next-state pointers; flush wins over any push/pop in the same cycle.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (clear) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
    end else begin
      if (push_acc) w_ptr_d = w_ptr_q + 1'b1;
      if (pop_acc)  r_ptr_d = r_ptr_q + 1'b1;
    end
  end

  // Pointer and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
    end else begin
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      push_err_q <= ~clear & push & full;
      pop_err_q  <= ~clear & pop & empty;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc && !clear) mem_q[w_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end

  assign push_err_on_full = push_err_q;
  assign pop_err_on_empty = pop_err_q;

`ifdef FIFO_FWFT_EN
  // Head word is shown as soon as it exists; pop just consumes it.
  always_comb begin
    data_valid = ~empty;
    data_out   = empty ? '0 : mem_q[r_ptr_q[ADDR_WIDTH-1:0]];
  end
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // Registered read: popped word appears the cycle after the pop edge and
  // is held until the next pop; flush drops valid but keeps the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop_acc;
      if (pop_acc) data_q <= mem_q[r_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_gen2.sv
// Directed bench for fifo_sync_gen2 (default parameters).
module tb_fifo_sync_gen2;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       push_err_on_full;
  logic       pop_err_on_empty;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  fifo_sync_gen2 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .push             (push),
    .pop              (pop),
    .data_in          (data_in),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .level            (level),
    .push_err_on_full (push_err_on_full),
    .pop_err_on_empty (pop_err_on_empty)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: one clock edge with the current inputs, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [7:0] d);
    push    = p;
    pop     = q;
    data_in = d;
  endtask

  task automatic check_reset_state();
    check_eq("rst_level", level, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_ae", almost_empty, 1);
    check_eq("rst_af", almost_full, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_perr", push_err_on_full, 0);
    check_eq("rst_oerr", pop_err_on_empty, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(0, 0, 8'h00);
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    step();

`ifdef FIFO_FWFT_EN
    drive(1, 0, 8'h11); step();
    check_eq("fw_dout1", data_out, 8'h11);
    check_eq("fw_valid1", data_valid, 1);
    drive(1, 0, 8'h22); step();
    check_eq("fw_dout_hold", data_out, 8'h11);
    check_eq("fw_level2", level, 2);
    drive(0, 1, 8'h00); step();
    check_eq("fw_dout2", data_out, 8'h22);
    check_eq("fw_valid2", data_valid, 1);
    step();
    check_eq("fw_valid_empty", data_valid, 0);
    check_eq("fw_empty", empty, 1);
    step();
    check_eq("fw_pop_err", pop_err_on_empty, 1);
    drive(1, 0, 8'h55); step();
    check_eq("fw_valid3", data_valid, 1);
    drive(0, 0, 8'h00); clear = 1'b1; step(); clear = 1'b0;
    check_eq("fw_clear_valid", data_valid, 0);
    check_eq("fw_clear_level", level, 0);
`else
    // 1: fill to full, then overflow attempt
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i)); step();
      exp_q.push_back(8'(i));
      check_eq("fill_level", level, i + 1);
      check_eq("fill_af", almost_full, (i + 1) >= 14);
      check_eq("fill_ae", almost_empty, (i + 1) <= 2);
      check_eq("fill_full", full, (i + 1) == 16);
    end
    drive(1, 0, 8'hAA); step();
    check_eq("ovf_err", push_err_on_full, 1);
    check_eq("ovf_level", level, 16);
    drive(0, 0, 8'h00); step();
    check_eq("ovf_err_clr", push_err_on_full, 0);

    // 2: drain in order, then underflow attempt
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'h00); step();
      check_eq("drain_valid", data_valid, 1);
      check_eq("drain_dout", data_out, exp_q.pop_front());
    end
    check_eq("drain_empty", empty, 1);
    step();
    check_eq("udf_err", pop_err_on_empty, 1);
    check_eq("udf_valid", data_valid, 0);
    check_eq("udf_dout_hold", data_out, 8'h0F);
    drive(0, 0, 8'h00); step();
    check_eq("udf_err_clr", pop_err_on_empty, 0);

    // 3: steady-state simultaneous push/pop at level 8
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'h20 + 8'(i)); step();
      exp_q.push_back(8'h20 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 8'h40 + 8'(i)); step();
      check_eq("rw_level", level, 8);
      check_eq("rw_valid", data_valid, 1);
      check_eq("rw_dout", data_out, exp_q.pop_front());
      check_eq("rw_errs", {push_err_on_full, pop_err_on_empty}, 0);
      exp_q.push_back(8'h40 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h00); step();
      check_eq("rw_drain", data_out, exp_q.pop_front());
    end
    check_eq("rw_empty", empty, 1);

    // 4: push+pop on empty
    drive(1, 1, 8'h5C); step();
    check_eq("pe_err", pop_err_on_empty, 1);
    check_eq("pe_level", level, 1);
    check_eq("pe_valid", data_valid, 0);
    drive(0, 1, 8'h00); step();
    check_eq("pe_dout", data_out, 8'h5C);
    check_eq("pe_valid2", data_valid, 1);
    check_eq("pe_level0", level, 0);

    // 5: clear with push, then reset mid-cycle
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h60 + 8'(i)); step();
    end
    check_eq("cl_level10", level, 10);
    clear = 1'b1; drive(1, 0, 8'h99); step(); clear = 1'b0;
    check_eq("cl_level", level, 0);
    check_eq("cl_empty", empty, 1);
    check_eq("cl_valid", data_valid, 0);
    drive(1, 0, 8'h33); step();
    drive(0, 1, 8'h00); step();
    check_eq("cl_dout", data_out, 8'h33);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'h70 + 8'(i)); step();
    end
    drive(0, 1, 8'h00); step();
    check_eq("mr_dout", data_out, 8'h70);
    drive(0, 0, 8'h00);
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    #1 rst_n = 1'b1;
    step();
    drive(1, 0, 8'h44); step();
    drive(0, 1, 8'h00); step();
    check_eq("mr_after", data_out, 8'h44);
    check_eq("mr_level", level, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_gen2.md
Name: fifo_sync_gen2

Overview:
Second-generation synchronous FIFO for the Go2UVM FIFO verification environment. Generalised in data width and depth. All 2**ADDR_WIDTH entries are usable.
Adds the following over the first generation:
- simultaneous push/pop in one cycle
- occupancy level output
- programmable almost-full/almost-empty flags
- synchronous flush
Sits between a producer and a consumer in the same clock domain.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries (2..1024)
AF_LEVEL, 2**ADDR_WIDTH-2, almost_full asserted when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; highest priority after reset
push  input  1  write request
pop  input  1  read request
data_in  input  DATA_WIDTH  write data, sampled when a push is accepted
data_out  output  DATA_WIDTH  read data
data_valid  output  1  data_out holds a newly popped word
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AF_LEVEL
almost_empty  output  1  level <= AE_LEVEL
level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
push_err_on_full  output  1  registered pulse: push attempted while full
pop_err_on_empty  output  1  registered pulse: pop attempted while empty

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: w_ptr=0, r_ptr=0, level=0, data_out=0, data_valid=0, push_err_on_full=0, pop_err_on_empty=0. Hence empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Pointers: w_ptr and r_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - Memory index = pointer[ADDR_WIDTH-1:0].
  - empty = (w_ptr == r_ptr).
  - full = (low bits equal and MSBs differ).
  - level = w_ptr - r_ptr, modulo 2**(ADDR_WIDTH+1).
- Status flags: full, empty, almost_full, almost_empty and level are combinational from registered pointers. They reflect state after the previous edge.
- Push acceptance: push_acc = push & ~full. On acceptance, mem[w_ptr] <= data_in and w_ptr increments.
- Pop acceptance: pop_acc = pop & ~empty. On acceptance, r_ptr increments.
- Simultaneous push & pop:
  - Neither full nor empty: both accepted in the same edge; level unchanged.
  - Empty: push accepted, pop rejected. No pass-through of data_in.
  - Full: pop accepted, push rejected.
- Read path (default): on pop_acc, data_out <= mem[r_ptr] and data_valid=1 for exactly the following cycle. Read latency is 1 cycle after the pop edge. data_out holds its value when there is no pop.
- Error pulses: push_err_on_full <= push & full; pop_err_on_empty <= pop & empty. Each is high for one cycle per offending cycle. State is not altered by a rejected request.
- clear: on an edge with clear=1, pointers go to 0 and data_valid to 0; push and pop in that cycle are ignored. Error outputs are cleared to 0. data_out holds its last value.
- Reset mid-operation: immediate return to reset values regardless of clk. The first push after deassertion is written to index 0.
- Wrap-around: pointers wrap naturally at 2**(ADDR_WIDTH+1). Ordering is preserved indefinitely.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- When defined (first-word fall-through):
  - data_out = mem[r_ptr[ADDR_WIDTH-1:0]] combinationally whenever not empty.
  - data_valid = ~empty.
  - pop acknowledges and removes the shown word; the next word appears after the same edge.
  - clear and reset force data_valid=0.
- When undefined: the registered read path described in Behaviour.
- All other behaviour is identical in both modes.

Test Plan:
All scenarios use defaults DATA_WIDTH=8, ADDR_WIDTH=4, AF_LEVEL=14, AE_LEVEL=2.
1. Reset, then push 0x00..0x0F over 16 cycles -> level=16, full=1, almost_full from level 14. Extra push 0xAA -> push_err_on_full=1 one cycle, level stays 16.
2. From full, pop 16 times -> data_out 0x00..0x0F in order, each with data_valid 1 cycle after its pop. empty=1; extra pop -> pop_err_on_empty=1, data_out holds 0x0F.
3. Fill to 8 entries, then 20 cycles of simultaneous push/pop with incrementing data -> level stays 8, pops return words in FIFO order, no error pulses.
4. Empty FIFO, push=1, pop=1 with data_in=0x5C -> push accepted, pop_err_on_empty=1, level=1. Next-cycle pop returns 0x5C.
5. Fill to 10, assert clear for 1 cycle with push=1 -> level=0, empty=1. Next push 0x33 then pop returns 0x33. Repeat with rst_n pulsed low mid-stream between edges -> outputs reset immediately.
6. With FIFO_FWFT_EN: push 0x11, 0x22 -> data_out=0x11 and data_valid=1 after the first push edge. pop -> data_out=0x22. pop -> data_valid=0.
